// File: rtl/cond_flag_stage.sv
// Execute-to-memory stage: owns the NZCV flags, evaluates the Execute
// condition code and registers the qualified instruction into M.
module cond_flag_stage #(
    parameter int WIDTH = 18,
    parameter int RA_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic             Flush,
    input  logic             ValidE,
    input  logic [3:0]       CondE,
    input  logic [1:0]       FlagWriteE,
    input  logic             RegWriteE,
    input  logic             MemWriteE,
    input  logic [RA_W-1:0]  WA3E,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic [WIDTH-1:0] WriteDataE,
    input  logic             ALUNegative,
    input  logic             ALUZero,
    input  logic             ALUCarry,
    input  logic             ALUOverFlow,
    output logic             CondExE,
    output logic [3:0]       Flags,
    output logic             ValidM,
    output logic             RegWriteM,
    output logic             MemWriteM,
    output logic [RA_W-1:0]  WA3M,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] WriteDataM
);

    typedef struct packed {
        logic             valid;
        logic             reg_we;
        logic             mem_we;
        logic [RA_W-1:0]  wa3;
        logic [WIDTH-1:0] result;
        logic [WIDTH-1:0] wdata;
    } ex_mem_t;

    ex_mem_t    r_m;
    logic [3:0] r_flags;

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_pass;
    logic w_upd;
    logic w_live;

    assign w_n = r_flags[3];
    assign w_z = r_flags[2];
    assign w_c = r_flags[1];
    assign w_v = r_flags[0];

    // Condition sees only the registered flags; no same-cycle ALU bypass.
    always_comb begin
        w_pass = 1'b0;
        unique case (CondE)
            4'b0000: w_pass = w_z;
            4'b0001: w_pass = ~w_z;
            4'b0010: w_pass = w_c;
            4'b0011: w_pass = ~w_c;
            4'b0100: w_pass = w_n;
            4'b0101: w_pass = ~w_n;
            4'b0110: w_pass = w_v;
            4'b0111: w_pass = ~w_v;
            4'b1000: w_pass = w_c & ~w_z;
            4'b1001: w_pass = ~w_c | w_z;
            4'b1010: w_pass = (w_n == w_v);
            4'b1011: w_pass = (w_n != w_v);
            4'b1100: w_pass = ~w_z & (w_n == w_v);
            4'b1101: w_pass = w_z | (w_n != w_v);
            4'b1110: w_pass = 1'b1;
            4'b1111: w_pass = 1'b0;
        endcase
    end

    assign w_live = ValidE & w_pass;
    assign w_upd  = w_live & ~Stall & ~Flush;

    // N,Z and C,V halves update independently.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_upd) begin
            if (FlagWriteE[1]) begin
                r_flags[3:2] <= {ALUNegative, ALUZero};
            end
            if (FlagWriteE[0]) begin
                r_flags[1:0] <= {ALUCarry, ALUOverFlow};
            end
        end
    end

    // Flush bubbles the control bits but leaves the data fields alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_m <= '0;
        end else if (Flush) begin
            r_m.valid  <= 1'b0;
            r_m.reg_we <= 1'b0;
            r_m.mem_we <= 1'b0;
        end else if (!Stall) begin
            r_m.valid  <= ValidE;
            r_m.reg_we <= RegWriteE & w_live;
            r_m.mem_we <= MemWriteE & w_live;
            r_m.wa3    <= WA3E;
            r_m.result <= ALUResultE;
            r_m.wdata  <= WriteDataE;
        end
    end

    assign CondExE    = w_pass;
    assign Flags      = r_flags;
    assign ValidM     = r_m.valid;
    assign RegWriteM  = r_m.reg_we;
    assign MemWriteM  = r_m.mem_we;
    assign WA3M       = r_m.wa3;
    assign ALUResultM = r_m.result;
    assign WriteDataM = r_m.wdata;

endmodule

// File: tb/tb_cond_flag_stage.sv
// Bench for cond_flag_stage: directed scenarios plus randomized traffic
// checked against a behavioural model of the flags and the M slot.
module tb_cond_flag_stage;

    localparam int WIDTH = 18;
    localparam int RA_W  = 4;
    localparam int VW    = 3 + RA_W + 2 * WIDTH + 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             Stall;
    logic             Flush;
    logic             ValidE;
    logic [3:0]       CondE;
    logic [1:0]       FlagWriteE;
    logic             RegWriteE;
    logic             MemWriteE;
    logic [RA_W-1:0]  WA3E;
    logic [WIDTH-1:0] ALUResultE;
    logic [WIDTH-1:0] WriteDataE;
    logic             ALUNegative;
    logic             ALUZero;
    logic             ALUCarry;
    logic             ALUOverFlow;
    logic             CondExE;
    logic [3:0]       Flags;
    logic             ValidM;
    logic             RegWriteM;
    logic             MemWriteM;
    logic [RA_W-1:0]  WA3M;
    logic [WIDTH-1:0] ALUResultM;
    logic [WIDTH-1:0] WriteDataM;

    int tests = 0;
    int fails = 0;

    // Model state
    logic [3:0]       mf;
    logic             mvalid, mrw, mmw;
    logic [RA_W-1:0]  mwa;
    logic [WIDTH-1:0] mres, mwd;

    cond_flag_stage #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
        .ValidE(ValidE), .CondE(CondE), .FlagWriteE(FlagWriteE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .WA3E(WA3E),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
        .ALUNegative(ALUNegative), .ALUZero(ALUZero),
        .ALUCarry(ALUCarry), .ALUOverFlow(ALUOverFlow),
        .CondExE(CondExE), .Flags(Flags), .ValidM(ValidM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .WA3M(WA3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM)
    );

    always #5 clk = ~clk;

    // Condition evaluated from the architectural meaning of each code.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, ge;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        ge = (n == v);
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !(cy && !z);
            4'd10: return ge;
            4'd11: return !ge;
            4'd12: return ge && !z;
            4'd13: return !(ge && !z);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {mvalid, mrw, mmw, mwa, mres, mwd, mf};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {ValidM, RegWriteM, MemWriteM, WA3M, ALUResultM, WriteDataM, Flags};
    endfunction

    task automatic drive_idle();
        reset = 0; Stall = 0; Flush = 0; ValidE = 0; CondE = 4'he;
        FlagWriteE = 0; RegWriteE = 0; MemWriteE = 0; WA3E = 0;
        ALUResultE = 0; WriteDataE = 0;
        ALUNegative = 0; ALUZero = 0; ALUCarry = 0; ALUOverFlow = 0;
    endtask

    task automatic drive_random();
        ValidE      = 1'($urandom);
        CondE       = 4'($urandom);
        FlagWriteE  = 2'($urandom);
        RegWriteE   = 1'($urandom);
        MemWriteE   = 1'($urandom);
        WA3E        = RA_W'($urandom);
        ALUResultE  = WIDTH'($urandom);
        WriteDataE  = WIDTH'($urandom);
        ALUNegative = 1'($urandom);
        ALUZero     = 1'($urandom);
        ALUCarry    = 1'($urandom);
        ALUOverFlow = 1'($urandom);
    endtask

    // Advance one clock; update the model from the pre-edge inputs.
    task automatic tick();
        logic ok;
        ok = ValidE && cond_ok(CondE, mf);
        @(posedge clk);
        if (reset) begin
            mf = 0; mvalid = 0; mrw = 0; mmw = 0;
            mwa = 0; mres = 0; mwd = 0;
        end else if (Flush) begin
            mvalid = 0; mrw = 0; mmw = 0;
        end else if (!Stall) begin
            if (ok && FlagWriteE[1]) begin
                mf[3] = ALUNegative; mf[2] = ALUZero;
            end
            if (ok && FlagWriteE[0]) begin
                mf[1] = ALUCarry; mf[0] = ALUOverFlow;
            end
            mvalid = ValidE;
            mrw = RegWriteE && ok;
            mmw = MemWriteE && ok;
            mwa = WA3E; mres = ALUResultE; mwd = WriteDataE;
        end
        #1;
    endtask

    task automatic test_reset();
        drive_random();
        reset = 1; Stall = 1; Flush = 0; ALUResultE = 18'h3FFFF;
        tick();
        tick();
        tests++;
        if (dut_vec() !== {VW{1'b0}}) begin
            $display("FAIL reset_state got=%h want=0", dut_vec());
            fails++;
        end
        drive_idle();
        Stall = 1;
        CondE = 4'b0000;
        #1;
        tests++;
        if (CondExE !== 1'b0) begin
            $display("FAIL reset_cond_eq got=%b want=0", CondExE);
            fails++;
        end
        tick();
        tests++;
        if (dut_vec() !== exp_vec()) begin
            $display("FAIL reset_release got=%h want=%h", dut_vec(), exp_vec());
            fails++;
        end
    endtask

    task automatic test_sub_then_eq();
        drive_idle();
        ValidE = 1; CondE = 4'b1110; FlagWriteE = 2'b11;
        ALUZero = 1; ALUCarry = 1; ALUResultE = 18'h00000;
        tick();
        tests++;
        if (Flags !== 4'b0110) begin
            $display("FAIL sub_flags got=%b want=0110", Flags);
            fails++;
        end
        drive_idle();
        ValidE = 1; CondE = 4'b0000; RegWriteE = 1; WA3E = 4'd5;
        ALUResultE = 18'h01234;
        #1;
        tests++;
        if (CondExE !== 1'b1) begin
            $display("FAIL eq_cond got=%b want=1", CondExE);
            fails++;
        end
        tick();
        tests++;
        if (RegWriteM !== 1'b1 || dut_vec() !== exp_vec()) begin
            $display("FAIL eq_regwrite got=%h want=%h", dut_vec(), exp_vec());
            fails++;
        end
    endtask

    task automatic test_cond_fail();
        drive_idle();
        ValidE = 1; CondE = 4'b1110; FlagWriteE = 2'b11; ALUNegative = 1;
        tick();
        tests++;
        if (Flags !== 4'b1000) begin
            $display("FAIL ge_setup got=%b want=1000", Flags);
            fails++;
        end
        drive_idle();
        ValidE = 1; CondE = 4'b1010; RegWriteE = 1; MemWriteE = 1;
        ALUResultE = 18'h2AAAA; WA3E = 4'd9;
        #1;
        tests++;
        if (CondExE !== 1'b0) begin
            $display("FAIL ge_cond got=%b want=0", CondExE);
            fails++;
        end
        tick();
        tests++;
        if ({ValidM, RegWriteM, MemWriteM} !== 3'b100 ||
            ALUResultM !== 18'h2AAAA) begin
            $display("FAIL ge_bubble got=%b%b%b res=%h want=100 res=2aaaa",
                     ValidM, RegWriteM, MemWriteM, ALUResultM);
            fails++;
        end
    endtask

    task automatic test_flag_halves();
        drive_idle();
        ValidE = 1; FlagWriteE = 2'b11; ALUCarry = 1; ALUOverFlow = 1;
        tick();
        drive_idle();
        ValidE = 1; FlagWriteE = 2'b10;
        ALUNegative = 0; ALUZero = 1; ALUCarry = 0; ALUOverFlow = 1;
        tick();
        tests++;
        if (Flags !== 4'b0111) begin
            $display("FAIL nz_half got=%b want=0111", Flags);
            fails++;
        end
        drive_idle();
        ValidE = 1; FlagWriteE = 2'b01; ALUNegative = 1; ALUCarry = 0;
        tick();
        tests++;
        if (Flags !== 4'b0100) begin
            $display("FAIL cv_half got=%b want=0100", Flags);
            fails++;
        end
        drive_idle();
        ValidE = 0; FlagWriteE = 2'b11; RegWriteE = 1; ALUNegative = 1;
        tick();
        tests++;
        if (Flags !== 4'b0100 || RegWriteM !== 1'b0 || ValidM !== 1'b0) begin
            $display("FAIL invalid_slot got=%b rw=%b want=0100 rw=0",
                     Flags, RegWriteM);
            fails++;
        end
    endtask

    task automatic test_stall();
        logic [VW-1:0] snap;
        snap = dut_vec();
        for (int i = 0; i < 3; i++) begin
            drive_random();
            Stall = 1; ValidE = 1; CondE = 4'b1110; FlagWriteE = 2'b11;
            tick();
            tests++;
            if (dut_vec() !== snap || dut_vec() !== exp_vec()) begin
                $display("FAIL stall_hold%0d got=%h want=%h", i, dut_vec(), snap);
                fails++;
            end
        end
        Stall = 0;
        tick();
        tests++;
        if (dut_vec() !== exp_vec() || ALUResultM !== ALUResultE) begin
            $display("FAIL stall_release got=%h want=%h", dut_vec(), exp_vec());
            fails++;
        end
    endtask

    task automatic test_flush();
        logic [3:0] f0;
        logic [WIDTH-1:0] r0;
        drive_idle();
        ValidE = 1; RegWriteE = 1; ALUResultE = 18'h1F00F; WA3E = 4'd3;
        tick();
        f0 = Flags; r0 = ALUResultM;
        drive_idle();
        Flush = 1; Stall = 1; ValidE = 1; RegWriteE = 1; MemWriteE = 1;
        FlagWriteE = 2'b11; ALUResultE = 18'h00055;
        ALUNegative = ~f0[3]; ALUZero = ~f0[2];
        ALUCarry = ~f0[1]; ALUOverFlow = ~f0[0];
        tick();
        tests++;
        if ({ValidM, RegWriteM, MemWriteM} !== 3'b000 ||
            ALUResultM !== r0 || Flags !== f0) begin
            $display("FAIL flush got=%b%b%b res=%h fl=%b want=000 res=%h fl=%b",
                     ValidM, RegWriteM, MemWriteM, ALUResultM, Flags, r0, f0);
            fails++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_random();
            reset = ($urandom_range(0, 49) == 0);
            Stall = ($urandom_range(0, 5) == 0);
            Flush = ($urandom_range(0, 7) == 0);
            #1;
            tests++;
            if (CondExE !== cond_ok(CondE, mf)) begin
                $display("FAIL rand_cond%0d c=%h fl=%b got=%b want=%b",
                         i, CondE, mf, CondExE, cond_ok(CondE, mf));
                fails++;
            end
            tick();
            tests++;
            if (dut_vec() !== exp_vec()) begin
                $display("FAIL rand_state%0d got=%h want=%h", i, dut_vec(), exp_vec());
                fails++;
            end
        end
    endtask

    initial begin
        mf = 0; mvalid = 0; mrw = 0; mmw = 0; mwa = 0; mres = 0; mwd = 0;
        drive_idle();
        @(posedge clk);
        #1;
        test_reset();
        test_sub_then_eq();
        test_cond_fail();
        test_flag_halves();
        test_stall();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cond_flag_stage.md
Name: cond_flag_stage

Overview:
Execute-to-memory boundary stage placed directly downstream of the 18-bit ALU. It holds the architectural NZCV flag register, which it updates from the ALU flag outputs. It evaluates the 4-bit condition code of the instruction currently in Execute against the stored flags. It registers the ALU result and the qualified control bits into the Memory-stage pipeline register, with stall and flush support.

Parameters:
WIDTH, 18, datapath width; matches ALU Result/A/B width
RA_W, 4, register-file write-address width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
Stall  in  1  hold the M register and the flags this cycle
Flush  in  1  squash the instruction in Execute (bubble into M)
ValidE  in  1  Execute slot holds a real instruction
CondE  in  4  condition code of the instruction in Execute
FlagWriteE  in  2  bit1 = write N,Z; bit0 = write C,V
RegWriteE  in  1  instruction writes the register file
MemWriteE  in  1  instruction writes memory
WA3E  in  RA_W  destination register address
ALUResultE  in  WIDTH  ALU Result
WriteDataE  in  WIDTH  store data
ALUNegative  in  1  ALU Negative
ALUZero  in  1  ALU Zero
ALUCarry  in  1  ALU Carry
ALUOverFlow  in  1  ALU OverFlow
CondExE  out  1  combinational: condition passes for the Execute instruction
Flags  out  4  registered {N,Z,C,V}
ValidM  out  1  M slot valid
RegWriteM  out  1  qualified register write
MemWriteM  out  1  qualified memory write
WA3M  out  RA_W  registered WA3E
ALUResultM  out  WIDTH  registered ALUResultE
WriteDataM  out  WIDTH  registered WriteDataE

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset: Flags=4'b0000; ValidM, RegWriteM, MemWriteM = 0; WA3M, ALUResultM, WriteDataM = 0.
- Edge priority: reset > Flush > Stall > normal load.
- CondExE is purely combinational from CondE and the registered Flags. There is no bypass of the ALU flags from the same cycle.
- Condition table:
  - 0000 Z; 0001 ~Z; 0010 C; 0011 ~C
  - 0100 N; 0101 ~N; 0110 V; 0111 ~V
  - 1000 C&~Z; 1001 ~C|Z
  - 1010 N==V; 1011 N!=V
  - 1100 ~Z&(N==V); 1101 Z|(N!=V)
  - 1110 1; 1111 0
- Flag update qualifier: upd = ValidE & CondExE & ~Stall & ~Flush.
  - On the edge, if upd & FlagWriteE[1]: N<=ALUNegative, Z<=ALUZero.
  - If upd & FlagWriteE[0]: C<=ALUCarry, V<=ALUOverFlow.
  - The two halves are independent. Otherwise the flags hold.
- Flag latency is 1 cycle. A flag-setting instruction in Execute at cycle t affects CondExE of the instruction in Execute at t+1.
- Flush (Stall ignored): ValidM, RegWriteM, MemWriteM <= 0. Data fields (WA3M, ALUResultM, WriteDataM) hold. No flag update.
- Stall without Flush: every M register and the flags hold their values.
- Normal load:
  - ValidM<=ValidE.
  - RegWriteM<=RegWriteE&ValidE&CondExE.
  - MemWriteM<=MemWriteE&ValidE&CondExE.
  - WA3M, ALUResultM, WriteDataM load unconditionally.
- A failed condition still advances ValidM=1 with both write enables 0. This keeps slot accounting intact.
- Invalid slot (ValidE=0): no flag change. The write enables are forced to 0.
- Reset asserted together with Stall or Flush: reset values win.
- Flags do not depend on ALUControl. The decoder must drive FlagWriteE[0]=0 for multiply/divide.

Test Plan:
- Reset held 2 cycles with ALUResultE=18'h3FFFF and Stall=1 -> after release, all outputs 0 and Flags=0000.
- SUB with ALUZero=1, ALUCarry=1, FlagWriteE=11, CondE=1110, ValidE=1 -> Flags=0110 next cycle. The following instruction with CondE=0000 gives CondExE=1 and, with RegWriteE=1, RegWriteM=1.
- Flags=1000 (N=1,V=0), CondE=1010 (GE), RegWriteE=1, MemWriteE=1 -> CondExE=0; next cycle ValidM=1, RegWriteM=0, MemWriteM=0, ALUResultM loaded.
- FlagWriteE=10, ALUNegative=0, ALUZero=1, ALUCarry=0, ALUOverFlow=1, Flags previously 0011 -> Flags=0111 (C,V preserved).
- Stall=1 for 3 cycles while the inputs change, FlagWriteE=11 -> M outputs and Flags are unchanged for all 3 cycles. On release, the current inputs load on the next edge.
- Flush=1 and Stall=1 together, RegWriteE=1, FlagWriteE=11, ALUResultE=18'h00055 -> ValidM=0, RegWriteM=0, MemWriteM=0, ALUResultM keeps its prior value, Flags unchanged.
